switch_debouncer: RTL
=====================

// Module: switch_debouncer
//
// PURPOSE
//   Conditions the raw slide-switch inputs before the MMIO block reads them.
//   Each bit goes through a 2-flop synchronizer and a per-bit stability counter.
//   The debounced vector drives the MMIO switches input (read at 0x40000004).
//   Also produces one-cycle edge pulses and sticky per-bit "changed" flags.
//
// PARAMETERS
//   WIDTH            10      number of switch bits
//   DEBOUNCE_CYCLES  500000  consecutive stable cycles needed to accept a level
//                            (10 ms at 50 MHz); legal range >= 1
//   CNT_W            derived localparam = $clog2(DEBOUNCE_CYCLES+1)
//
// PORTS
//   clk          in   1      system clock
//   reset        in   1      asynchronous, active-high reset
//   sw_raw       in   WIDTH  raw switch pins, asynchronous to clk
//   sw_clean     out  WIDTH  debounced level, registered; feeds mmio switches
//   sw_rise      out  WIDTH  1-cycle pulse when sw_clean[i] goes 0->1
//   sw_fall      out  WIDTH  1-cycle pulse when sw_clean[i] goes 1->0
//   sw_changed   out  WIDTH  sticky: sw_clean[i] has toggled since last clear
//   clr_changed  in   WIDTH  write-one-to-clear for sw_changed, sampled each edge
//
// BEHAVIOUR
//   - Reset (async assert, sync use): the following all go to 0:
//     sync1, sync2, every cnt[i], sw_clean, sw_rise, sw_fall, sw_changed.
//   - Synchronizer: sync1 <= sw_raw; sync2 <= sync1. This is the only use of sw_raw.
//   - Per bit i, each edge:
//       sync2[i] == sw_clean[i]            : cnt[i] <= 0
//       mismatch, cnt[i] <  DEBOUNCE_CYCLES-1 : cnt[i] <= cnt[i]+1
//       mismatch, cnt[i] == DEBOUNCE_CYCLES-1 : sw_clean[i] <= sync2[i]; cnt[i] <= 0
//   - A glitch shorter than DEBOUNCE_CYCLES mismatch cycles restarts the counter.
//     sw_clean never changes on such a glitch.
//   - Counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
//   - Latency: sw_raw is first captured into sync1 on edge 0.
//     sw_clean updates on edge DEBOUNCE_CYCLES+1, if the level is held throughout.
//   - sw_rise[i] / sw_fall[i]:
//       registered, asserted on the same edge that updates sw_clean[i];
//       high for exactly one cycle; never both high for the same bit.
//   - sw_changed[i]:
//       set on the update edge; cleared when clr_changed[i]=1.
//       Set and clear on the same edge: set wins (stays 1).
//   - Bits are fully independent. Any combination may update on the same edge.
//   - Switches already high at reset release produce a sw_rise after the
//     debounce latency. This is intended.
//   - Reset mid-count: the count is discarded, no pulse is emitted,
//     and debounce restarts from sw_clean=0.
//   - DEBOUNCE_CYCLES=1: a new level is accepted on the first mismatch edge
//     (edge 2 after capture).
//
// TESTING  (bench uses WIDTH=10, DEBOUNCE_CYCLES=4)
//   1. Release reset with sw_raw=0 -> sw_clean, sw_rise, sw_fall, sw_changed
//      all 0 for 20 cycles.
//   2. sw_raw=10'h001, captured at edge 0 -> sw_clean=10'h001 after edge 5;
//      sw_rise=10'h001 for that one cycle only; sw_changed[0]=1.
//   3. Bit 3 glitches high for 3 cycles, then low -> sw_clean[3] stays 0;
//      no sw_rise[3].
//   4. Bit 0 goes 1->0 while bit 9 goes 0->1 on the same edge ->
//      sw_clean=10'h200 after edge 5; sw_fall[0] and sw_rise[9] pulse together.
//   5. clr_changed=10'h001 pulsed -> sw_changed[0]=0 next cycle.
//      clr_changed pulsed on the same edge as a bit-0 update -> sw_changed[0]
//      stays 1.
//   6. Assert reset while cnt[5]=2 -> all outputs 0 immediately (async).
//      After release with sw_raw[5]=1 held, sw_rise[5] pulses after edge 5.

Source files
------------

// File: rtl/switch_debouncer_if.sv
// Switch conditioning bus: raw switch pins and the write-one-to-clear control
// flow into the debouncer; debounced level, edge pulses and sticky change
// flags flow back out to the MMIO side.
interface switch_debouncer_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] clr_changed;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic [WIDTH-1:0] sw_changed;

    // Environment side: drives the pins and the clear strobe, reads results.
    modport master (
        output sw_raw,
        output clr_changed,
        input  sw_clean,
        input  sw_rise,
        input  sw_fall,
        input  sw_changed
    );

    // Debouncer side.
    modport slave (
        input  sw_raw,
        input  clr_changed,
        output sw_clean,
        output sw_rise,
        output sw_fall,
        output sw_changed
    );
endinterface

// File: rtl/switch_debouncer.sv
// Slide-switch conditioner. Each bit passes through a two-flop synchronizer
// and then a stability counter. A new level is accepted only after it has
// disagreed with the current debounced level for DEBOUNCE_CYCLES consecutive
// edges. The accept edge also raises a one-cycle rise/fall pulse and sets a
// sticky changed flag, which software clears with a write-one-to-clear strobe.
// All outputs come straight from flops.
module switch_debouncer #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                reset,
    switch_debouncer_if.slave   sw_bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Terminal count: the mismatch edge that sees this value accepts the level.
    localparam logic [CNT_W-1:0] CNT_MAX_C  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};

    // Synchronizer stages; sync1_r is the only flop that sees sw_raw.
    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;

    // Per-bit stability counters, saturating at CNT_MAX_C.
    logic [CNT_W-1:0] cnt_r [WIDTH];
    logic [CNT_W-1:0] cnt_nxt_s [WIDTH];

    // Registered outputs.
    logic [WIDTH-1:0] clean_r;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;
    logic [WIDTH-1:0] changed_r;

    // Bits whose new level is accepted on the coming edge.
    logic [WIDTH-1:0] accept_s;
    logic [WIDTH-1:0] mismatch_s;

    assign mismatch_s = sync2_r ^ clean_r;

    // Next-count and accept decision for every bit, each bit independent.
    always_comb begin
        accept_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt_s[i] = CNT_ZERO_C;
            if (!mismatch_s[i]) begin
                cnt_nxt_s[i] = CNT_ZERO_C;
            end else if (cnt_r[i] == CNT_MAX_C) begin
                // Level held long enough: accept it and rearm the counter.
                cnt_nxt_s[i] = CNT_ZERO_C;
                accept_s[i]  = 1'b1;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE_C;
            end
        end
    end

    // Synchronizer, counters, debounced level, edge pulses and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r   <= {WIDTH{1'b0}};
            sync2_r   <= {WIDTH{1'b0}};
            clean_r   <= {WIDTH{1'b0}};
            rise_r    <= {WIDTH{1'b0}};
            fall_r    <= {WIDTH{1'b0}};
            changed_r <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= CNT_ZERO_C;
            end
        end else begin
            sync1_r   <= sw_bus.sw_raw;
            sync2_r   <= sync1_r;
            // An accepted bit always flips, since acceptance implies mismatch.
            clean_r   <= clean_r ^ accept_s;
            rise_r    <= accept_s & sync2_r;
            fall_r    <= accept_s & ~sync2_r;
            // Set has priority over a simultaneous clear so no toggle is lost.
            changed_r <= (changed_r & ~sw_bus.clr_changed) | accept_s;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign sw_bus.sw_clean   = clean_r;
    assign sw_bus.sw_rise    = rise_r;
    assign sw_bus.sw_fall    = fall_r;
    assign sw_bus.sw_changed = changed_r;

endmodule
